sipo_deserializer: RTL

- Serial-in, parallel-out receive stage; the consumer of the serial stream produced by our parallel-in/serial-out shift register.
- Collects WIDTH serial bits into a word, framed by a start marker, and presents each word on a valid/ready output holding register.
- Flags overrun (word lost because the consumer is stalled) and framing error (start marker arrives mid-word).

---
 rtl/sipo_deserializer_if.sv | 28 ++
 rtl/sipo_deserializer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer_if.sv
// Purpose : bus bundle for the serial-in/parallel-out receive stage.
//           Carries the serial input side (sin, sin_valid, start) and the
//           parallel output handshake (out_data, out_valid, out_ready).
// Ports   : master - drives the serial stream and out_ready, observes the word
//           slave  - the deserializer: consumes the stream, presents the word
// Handshake: a word transfers on a posedge where out_valid=1 and out_ready=1.
//           The slave holds out_data stable while out_valid=1 and the word has
//           not transferred. out_valid never depends combinationally on out_ready.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             sin;
  logic             sin_valid;
  logic             start;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;

  modport master (
    output sin, sin_valid, start, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  sin, sin_valid, start, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Purpose : collects WIDTH serial bits framed by a start marker into a word
//           and presents it on a valid/ready holding register. Flags words
//           lost to a stalled consumer (overrun) and start markers arriving
//           inside a word (frame_err). Both flags are sticky until err_clr.
// Ports   : clk       - clock, all state changes on posedge
//           clr       - asynchronous active-low reset
//           bus       - sipo_deserializer_if.slave (sin, sin_valid, start,
//                       out_ready in; out_data, out_valid out)
//           err_clr   - synchronous clear of overrun / frame_err
//           busy      - a word is partially received
//           overrun   - sticky, a completed word was dropped
//           frame_err - sticky, start arrived before a word completed
//           dbg_state - raw receive FSM state
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 clr,
  sipo_deserializer_if.slave   bus,
  input  logic                 err_clr,
  output logic                 busy,
  output logic                 overrun,
  output logic                 frame_err,
  output logic [0:0]           dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_q, frame_d;
  logic             complete;
  logic             frame_set;
  logic             overrun_set;

  // LSB-first: new bit enters at the MSB and the register shifts right, so
  // after WIDTH bits the first one has travelled down to bit 0.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r,
                                                input logic b);
    if (LSB_FIRST)
      return {b, r[WIDTH-1:1]};
    else
      return {r[WIDTH-2:0], b};
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      frame_q   <= frame_d;
    end
  end

  // Receive FSM: bit collection and word completion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    complete  = 1'b0;
    frame_set = 1'b0;
    if (bus.sin_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Start from a cleared register so the new word carries no
            // leftover bits from a previous frame.
            sh_d    = shift_in('0, bus.sin);
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (bus.start) begin
            frame_set = 1'b1;
            sh_d      = shift_in('0, bus.sin);
            cnt_d     = CW'(1);
          end else begin
            sh_d = shift_in(sh_q, bus.sin);
            if (cnt_q == CW'(WIDTH - 1)) begin
              complete = 1'b1;
              cnt_d    = '0;
              state_d  = IDLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output holding register and sticky flags.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_set = 1'b0;
    if (complete) begin
      // A completing word may replace a held word only if that held word
      // transfers on this same edge.
      if (!valid_q || bus.out_ready) begin
        data_d  = sh_d;
        valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
    // A new event on the same edge as err_clr keeps the flag set.
    overrun_d = overrun_set | (overrun_q & ~err_clr);
    frame_d   = frame_set   | (frame_q   & ~err_clr);
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign busy          = (state_q == SHIFT);
  assign overrun       = overrun_q;
  assign frame_err     = frame_q;
  assign dbg_state     = state_q;

endmodule
